timer_output_stage: RTL and testbench

//  Output half of an advanced-timer channel: counter/threshold compare -> action -> dead-time -> polarity.

---
 rtl/timer_output_stage_pkg.sv | 67 ++++++
 rtl/timer_output_stage_if.sv | 35 +++
 rtl/timer_deadtime_gen.sv | 88 ++++++++
 rtl/timer_output_stage.sv | 88 ++++++++
 tb/tb_timer_output_stage.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_output_stage_pkg.sv
// Shared types for the timer output stage: action codes, dead-time states,
// and the decode from an action code to its match/end edge actions.
package timer_out_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DT_W_DEF  = 8;

  typedef enum logic [2:0] {
    OP_SET      = 3'b000,
    OP_TOG_CLR  = 3'b001,
    OP_SET_CLR  = 3'b010,
    OP_TOG      = 3'b011,
    OP_CLR      = 3'b100,
    OP_TOG_SET  = 3'b101,
    OP_CLR_SET  = 3'b110,
    OP_HOLD     = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_DT_R,
    S_HIGH,
    S_DT_F
  } dt_state_e;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_SET,
    ACT_CLR,
    ACT_TOG
  } act_e;

  typedef struct packed {
    act_e on_match;
    act_e on_end;
  } op_act_t;

  function automatic op_act_t decode_op(op_e op);
    op_act_t a;
    a = '{on_match: ACT_NONE, on_end: ACT_NONE};
    unique case (op)
      OP_SET:     a = '{on_match: ACT_SET,  on_end: ACT_NONE};
      OP_TOG_CLR: a = '{on_match: ACT_TOG,  on_end: ACT_CLR};
      OP_SET_CLR: a = '{on_match: ACT_SET,  on_end: ACT_CLR};
      OP_TOG:     a = '{on_match: ACT_TOG,  on_end: ACT_NONE};
      OP_CLR:     a = '{on_match: ACT_CLR,  on_end: ACT_NONE};
      OP_TOG_SET: a = '{on_match: ACT_TOG,  on_end: ACT_SET};
      OP_CLR_SET: a = '{on_match: ACT_CLR,  on_end: ACT_SET};
      OP_HOLD:    a = '{on_match: ACT_NONE, on_end: ACT_NONE};
      default:    a = '{on_match: ACT_NONE, on_end: ACT_NONE};
    endcase
    return a;
  endfunction

  function automatic logic apply_act(act_e a, logic v);
    logic r;
    unique case (a)
      ACT_SET: r = 1'b1;
      ACT_CLR: r = 1'b0;
      ACT_TOG: r = ~v;
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_output_stage_if.sv
// Control, counter, configuration and pin bundle of one timer output channel.
interface timer_output_stage_if
  import timer_out_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DT_W  = DT_W_DEF
);
  logic             ctrl_active_i;
  logic             ctrl_update_i;
  logic             ctrl_rst_i;
  logic             cnt_evt_i;
  logic             cnt_end_i;
  logic [CNT_W-1:0] cnt_i;
  logic [CNT_W-1:0] cfg_comp_i;
  logic [2:0]       cfg_op_i;
  logic [DT_W-1:0]  cfg_dt_i;
  logic             cfg_pol_i;
  logic             pwm_o;
  logic             pwm_n_o;
  logic             match_o;

  modport master (
    output ctrl_active_i, ctrl_update_i, ctrl_rst_i,
    output cnt_evt_i, cnt_end_i, cnt_i,
    output cfg_comp_i, cfg_op_i, cfg_dt_i, cfg_pol_i,
    input  pwm_o, pwm_n_o, match_o
  );

  modport slave (
    input  ctrl_active_i, ctrl_update_i, ctrl_rst_i,
    input  cnt_evt_i, cnt_end_i, cnt_i,
    input  cfg_comp_i, cfg_op_i, cfg_dt_i, cfg_pol_i,
    output pwm_o, pwm_n_o, match_o
  );
endinterface

// File: rtl/timer_deadtime_gen.sv
// Dead-time generator: turns the channel level into a complementary pair,
// inserting dt cycles with both sides off before any side turns on.
module timer_deadtime_gen
  import timer_out_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            active,
  input  logic            clr,
  input  logic            level,
  input  logic [DT_W-1:0] dt,
  output logic            p,
  output logic            n
);

  dt_state_e       state, state_nxt;
  logic [DT_W-1:0] dt_cnt, dt_cnt_nxt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= S_OFF;
      dt_cnt <= '0;
    end else begin
      state  <= state_nxt;
      dt_cnt <= dt_cnt_nxt;
    end
  end

  // The dead-time length is latched on entry, so dt edits only affect the next transition.
  always_comb begin
    state_nxt  = state;
    dt_cnt_nxt = dt_cnt;
    if (clr) begin
      state_nxt = S_LOW;
    end else if (active) begin
      unique case (state)
        S_OFF: state_nxt = S_LOW;
        S_LOW: begin
          if (level) begin
            if (dt == '0) begin
              state_nxt = S_HIGH;
            end else begin
              state_nxt  = S_DT_R;
              dt_cnt_nxt = dt;
            end
          end
        end
        S_DT_R: begin
          if (!level)                     state_nxt  = S_LOW;
          else if (dt_cnt == DT_W'(1))    state_nxt  = S_HIGH;
          else                            dt_cnt_nxt = dt_cnt - DT_W'(1);
        end
        S_HIGH: begin
          if (!level) begin
            if (dt == '0) begin
              state_nxt = S_LOW;
            end else begin
              state_nxt  = S_DT_F;
              dt_cnt_nxt = dt;
            end
          end
        end
        S_DT_F: begin
          if (level)                      state_nxt  = S_HIGH;
          else if (dt_cnt == DT_W'(1))    state_nxt  = S_LOW;
          else                            dt_cnt_nxt = dt_cnt - DT_W'(1);
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  always_comb begin
    p = 1'b0;
    n = 1'b0;
    unique case (state)
      S_LOW:   n = 1'b1;
      S_HIGH:  p = 1'b1;
      default: begin
        p = 1'b0;
        n = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/timer_output_stage.sv
// Output half of a timer channel: shadowed config, compare/end actions on the
// channel level, dead-time pair generation and output polarity.
module timer_output_stage
  import timer_out_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DT_W  = DT_W_DEF
) (
  input logic                clk_i,
  input logic                rstn_i,
  timer_output_stage_if.slave bus
);

  typedef struct packed {
    logic [CNT_W-1:0] comp;
    op_e              op;
    logic [DT_W-1:0]  dt;
    logic             pol;
  } cfg_t;

  localparam cfg_t CFG_RST = '{comp: '0, op: OP_SET, dt: '0, pol: 1'b0};

  cfg_t    r_cfg, r_pend_cfg, cfg_in;
  logic    r_pend;
  logic    r_out, r_match;
  logic    hit, out_after_end, out_nxt;
  op_act_t acts;
  logic    dt_p, dt_n;

  always_comb begin
    cfg_in = '{comp: bus.cfg_comp_i, op: op_e'(bus.cfg_op_i),
               dt: bus.cfg_dt_i, pol: bus.cfg_pol_i};
  end

  // End action applies first so a coincident match has the final word.
  always_comb begin
    hit           = bus.cnt_evt_i && (bus.cnt_i == r_cfg.comp);
    acts          = decode_op(r_cfg.op);
    out_after_end = bus.cnt_end_i ? apply_act(acts.on_end, r_out) : r_out;
    out_nxt       = hit ? apply_act(acts.on_match, out_after_end) : out_after_end;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cfg      <= CFG_RST;
      r_pend_cfg <= CFG_RST;
      r_pend     <= 1'b0;
      r_out      <= 1'b0;
      r_match    <= 1'b0;
    end else if (bus.ctrl_rst_i) begin
      r_out   <= 1'b0;
      r_match <= 1'b0;
      r_pend  <= 1'b0;
    end else if (bus.ctrl_active_i) begin
      r_out   <= out_nxt;
      r_match <= hit;
      if (bus.cnt_end_i && (r_pend || bus.ctrl_update_i)) begin
        r_cfg  <= bus.ctrl_update_i ? cfg_in : r_pend_cfg;
        r_pend <= 1'b0;
      end else if (bus.ctrl_update_i) begin
        r_pend_cfg <= cfg_in;
        r_pend     <= 1'b1;
      end
    end else begin
      r_match <= 1'b0;
      if (bus.ctrl_update_i) begin
        r_cfg  <= cfg_in;
        r_pend <= 1'b0;
      end
    end
  end

  timer_deadtime_gen #(.DT_W(DT_W)) u_deadtime (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .active (bus.ctrl_active_i),
    .clr    (bus.ctrl_rst_i),
    .level  (r_out),
    .dt     (r_cfg.dt),
    .p      (dt_p),
    .n      (dt_n)
  );

  assign bus.pwm_o   = dt_p ^ r_cfg.pol;
  assign bus.pwm_n_o = dt_n ^ r_cfg.pol;
  assign bus.match_o = r_match;

endmodule

// File: tb/tb_timer_output_stage.sv
// Bench for timer_output_stage: directed vector table, corner sequences and a
// randomized run against a run-length reference model of the channel.
module tb_timer_output_stage;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DT_W  = 8;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  timer_output_stage_if #(.CNT_W(CNT_W), .DT_W(DT_W)) bus ();

  timer_output_stage #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  typedef struct {
    logic evt;
    logic endp;
    int   cnt;
    logic pwm;
    logic pwm_n;
    logic match;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.ctrl_active_i = 1'b0;
    bus.ctrl_update_i = 1'b0;
    bus.ctrl_rst_i    = 1'b0;
    bus.cnt_evt_i     = 1'b0;
    bus.cnt_end_i     = 1'b0;
    bus.cnt_i         = '0;
    bus.cfg_comp_i    = '0;
    bus.cfg_op_i      = '0;
    bus.cfg_dt_i      = '0;
    bus.cfg_pol_i     = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_pwm", bus.pwm_o, 0);
    chk("reset_pwm_n", bus.pwm_n_o, 0);
    chk("reset_match", bus.match_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic load_cfg(input int op, input int comp, input int dt, input int pol);
    @(negedge clk_i);
    bus.ctrl_active_i = 1'b0;
    bus.cfg_op_i      = 3'(op);
    bus.cfg_comp_i    = 16'(comp);
    bus.cfg_dt_i      = 8'(dt);
    bus.cfg_pol_i     = 1'(pol);
    bus.ctrl_update_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.ctrl_update_i = 1'b0;
  endtask

  task automatic step(input logic evt, input logic endp, input int cnt);
    @(negedge clk_i);
    bus.cnt_evt_i = evt;
    bus.cnt_end_i = endp;
    bus.cnt_i     = 16'(cnt);
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: the channel level follows the action table; a pin side turns
  // on once the level has been stable for dt+1 active cycles, or immediately when
  // the level returns to the side that was already on.
  byte m_match_act[8] = '{"S", "T", "S", "T", "C", "T", "C", "H"};
  byte m_end_act[8]   = '{"-", "C", "C", "-", "-", "S", "S", "-"};
  int  m_off, m_p, m_n, m_ro, m_match, m_pend;
  int  m_settled, m_run_val, m_run_len, m_run_dt;
  int  m_comp, m_op, m_dt, m_pol;
  int  q_comp, q_op, q_dt, q_pol;

  function automatic int apply(input byte a, input int v);
    if (a == "S") return 1;
    if (a == "C") return 0;
    if (a == "T") return 1 - v;
    return v;
  endfunction

  task automatic model_reset();
    m_off = 1; m_p = 0; m_n = 0; m_ro = 0; m_match = 0; m_pend = 0;
    m_settled = 0; m_run_val = 0; m_run_len = 0; m_run_dt = 0;
    m_comp = 0; m_op = 0; m_dt = 0; m_pol = 0;
    q_comp = 0; q_op = 0; q_dt = 0; q_pol = 0;
  endtask

  task automatic model_step();
    int act, upd, crst, evt, endp, hit, v;
    act  = int'(bus.ctrl_active_i);
    upd  = int'(bus.ctrl_update_i);
    crst = int'(bus.ctrl_rst_i);
    evt  = int'(bus.cnt_evt_i);
    endp = int'(bus.cnt_end_i);
    if (crst != 0 || (act != 0 && m_off != 0)) begin
      m_off = 0; m_settled = 0; m_run_val = 0; m_run_len = 1; m_p = 0; m_n = 1;
    end else if (act != 0) begin
      if (m_ro != m_run_val) begin
        m_run_val = m_ro; m_run_len = 1; m_run_dt = m_dt;
      end else begin
        m_run_len++;
      end
      if (m_run_val == m_settled || m_run_len >= m_run_dt + 1) begin
        m_settled = m_run_val; m_p = m_run_val; m_n = 1 - m_run_val;
      end else begin
        m_p = 0; m_n = 0;
      end
    end
    if (crst != 0) begin
      m_ro = 0; m_match = 0; m_pend = 0;
    end else if (act != 0) begin
      hit = (evt != 0 && int'(bus.cnt_i) == m_comp) ? 1 : 0;
      v = m_ro;
      if (endp != 0) v = apply(m_end_act[m_op], v);
      if (hit != 0)  v = apply(m_match_act[m_op], v);
      m_ro = v;
      m_match = hit;
      if (endp != 0 && (m_pend != 0 || upd != 0)) begin
        if (upd != 0) begin
          m_comp = int'(bus.cfg_comp_i); m_op = int'(bus.cfg_op_i);
          m_dt = int'(bus.cfg_dt_i); m_pol = int'(bus.cfg_pol_i);
        end else begin
          m_comp = q_comp; m_op = q_op; m_dt = q_dt; m_pol = q_pol;
        end
        m_pend = 0;
      end else if (upd != 0) begin
        q_comp = int'(bus.cfg_comp_i); q_op = int'(bus.cfg_op_i);
        q_dt = int'(bus.cfg_dt_i); q_pol = int'(bus.cfg_pol_i);
        m_pend = 1;
      end
    end else begin
      m_match = 0;
      if (upd != 0) begin
        m_comp = int'(bus.cfg_comp_i); m_op = int'(bus.cfg_op_i);
        m_dt = int'(bus.cfg_dt_i); m_pol = int'(bus.cfg_pol_i);
        m_pend = 0;
      end
    end
  endtask

  vec_t t1[12];

  initial begin
    idle_inputs();

    // Set-on-match / clear-on-end with no dead-time over one period.
    for (int i = 0; i < 5; i++) t1[i] = '{1'b1, 1'b0, i, 1'b0, 1'b1, 1'b0};
    t1[5]  = '{1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b1};
    t1[6]  = '{1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0};
    t1[7]  = '{1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b0};
    t1[8]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0};
    t1[9]  = '{1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0};
    t1[10] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    t1[11] = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};

    do_reset();
    load_cfg(2, 5, 0, 0);
    bus.ctrl_active_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(t1[i].evt, t1[i].endp, t1[i].cnt);
      chk($sformatf("t1_pwm[%0d]", i), bus.pwm_o, t1[i].pwm);
      chk($sformatf("t1_pwm_n[%0d]", i), bus.pwm_n_o, t1[i].pwm_n);
      chk($sformatf("t1_match[%0d]", i), bus.match_o, t1[i].match);
    end

    // Rising edge delayed by dt=3.
    do_reset();
    load_cfg(3, 2, 3, 0);
    bus.ctrl_active_i = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 2);
    chk("t2_match", bus.match_o, 1);
    step(1'b0, 1'b0, 2);
    chk("t2_n_off", bus.pwm_n_o, 0);
    chk("t2_p_dt1", bus.pwm_o, 0);
    step(1'b0, 1'b0, 2);
    chk("t2_p_dt2", bus.pwm_o, 0);
    step(1'b0, 1'b0, 2);
    chk("t2_p_dt3", bus.pwm_o, 0);
    step(1'b0, 1'b0, 2);
    chk("t2_p_on", bus.pwm_o, 1);
    chk("t2_n_stay", bus.pwm_n_o, 0);

    // Level pulse shorter than dt aborts the rising transition.
    do_reset();
    load_cfg(3, 2, 4, 0);
    bus.ctrl_active_i = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 2);
    chk("t3_p_a", bus.pwm_o, 0);
    chk("t3_n_a", bus.pwm_n_o, 0);
    step(1'b1, 1'b0, 2);
    chk("t3_p_b", bus.pwm_o, 0);
    chk("t3_n_b", bus.pwm_n_o, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 0);
      chk($sformatf("t3_p_after[%0d]", i), bus.pwm_o, 0);
      chk($sformatf("t3_n_after[%0d]", i), bus.pwm_n_o, 1);
    end

    // Coincident end (set) and match (toggle): match wins, level ends low.
    do_reset();
    load_cfg(5, 9, 0, 0);
    bus.ctrl_active_i = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 9);
    chk("t4_match", bus.match_o, 1);
    step(1'b0, 1'b0, 0);
    chk("t4_pwm", bus.pwm_o, 0);
    chk("t4_pwm_n", bus.pwm_n_o, 1);
    chk("t4_match_drop", bus.match_o, 0);
    step(1'b0, 1'b0, 0);
    chk("t4_pwm_late", bus.pwm_o, 0);

    // Update while running takes effect only at the period end.
    do_reset();
    load_cfg(7, 5, 0, 0);
    bus.ctrl_active_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 10; c++) begin
        if (p == 0 && c == 3) begin
          @(negedge clk_i);
          bus.cfg_comp_i    = 16'd7;
          bus.ctrl_update_i = 1'b1;
        end
        step(1'b1, c == 9, c);
        bus.ctrl_update_i = 1'b0;
        chk($sformatf("t5_match[%0d.%0d]", p, c), bus.match_o, (c == ((p == 0) ? 5 : 7)) ? 1 : 0);
        chk($sformatf("t5_hold[%0d.%0d]", p, c), bus.pwm_o, 0);
      end
    end

    // Inverted polarity, then asynchronous reset during dead-time.
    do_reset();
    load_cfg(0, 1, 4, 1);
    chk("t6_off_pwm", bus.pwm_o, 1);
    chk("t6_off_pwm_n", bus.pwm_n_o, 1);
    bus.ctrl_active_i = 1'b1;
    step(1'b1, 1'b0, 0);
    chk("t6_low_pwm", bus.pwm_o, 1);
    chk("t6_low_pwm_n", bus.pwm_n_o, 0);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1);
    chk("t6_dt_pwm", bus.pwm_o, 1);
    chk("t6_dt_pwm_n", bus.pwm_n_o, 1);
    #3;
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_pwm", bus.pwm_o, 0);
    chk("t6_rst_pwm_n", bus.pwm_n_o, 0);
    chk("t6_rst_match", bus.match_o, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_i);
      bus.ctrl_active_i = ($urandom_range(0, 9) != 0);
      bus.ctrl_update_i = ($urandom_range(0, 9) == 0);
      bus.ctrl_rst_i    = ($urandom_range(0, 39) == 0);
      bus.cnt_evt_i     = ($urandom_range(0, 3) != 0);
      bus.cnt_end_i     = ($urandom_range(0, 7) == 0);
      bus.cnt_i         = 16'($urandom_range(0, 7));
      bus.cfg_comp_i    = 16'($urandom_range(0, 7));
      bus.cfg_op_i      = 3'($urandom_range(0, 7));
      bus.cfg_dt_i      = 8'($urandom_range(0, 3));
      bus.cfg_pol_i     = ($urandom_range(0, 5) == 0);
      @(posedge clk_i);
      model_step();
      #1;
      chk($sformatf("rnd_pwm[%0d]", i), bus.pwm_o, 32'(m_p ^ m_pol));
      chk($sformatf("rnd_pwm_n[%0d]", i), bus.pwm_n_o, 32'(m_n ^ m_pol));
      chk($sformatf("rnd_match[%0d]", i), bus.match_o, 32'(m_match));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
